hs_rr_arbiter: RTL and testbench

- Shares one downstream valid/ready channel among NUM_REQ upstream valid/ready requesters.
- Uses round-robin arbitration and a registered output stage.
- Output slice has bubble-free semantics: a new beat is accepted whenever the stage is empty or being drained in the same cycle.
- Sits in front of shared consumers (e.g. a single processing engine) that feed from several producers.

---
 rtl/hs_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 25 ++
 rtl/hs_rr_arbiter.sv | 95 +++++++++
 tb/tb_hs_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: default sizes and index helpers shared by the round-robin arbiter
package hs_arb_pkg;
    localparam int NUM_REQ_DEF    = 4;
    localparam int WORD_WIDTH_DEF = 32;
    localparam int ID_WIDTH_DEF   = 2;
    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
    function automatic int next_ptr(input int id, input int num);
        return (id >= num - 1) ? 0 : id + 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first requester at or after ptr wins
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any
);
    logic [NUM_REQ-1:0] rot;
    assign rot = NUM_REQ'({req, req} >> ptr);
    always_comb begin
        grant_id = '0;
        any      = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any      = 1'b1;
                grant_id = ID_WIDTH'((int'(ptr) + j) % NUM_REQ);
            end
        end
        grant = any ? (NUM_REQ'(1) << grant_id) : '0;
    end
endmodule

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin valid/ready mux with bubble-free output register; HS_RR_ARB_LAST_LOCK_EN adds packet locking
module hs_rr_arbiter
    import hs_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            up_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] up_data,
    output logic [NUM_REQ-1:0]            up_ready,
    output logic                          down_valid,
    output logic [WORD_WIDTH-1:0]         down_data,
    output logic [ID_WIDTH-1:0]           down_id,
    input  logic                          down_ready
`ifdef HS_RR_ARB_LAST_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]            up_last,
    output logic                          down_last
`endif
);
    if (ID_WIDTH < clog2(NUM_REQ)) begin : g_id_width_check
        $error("hs_rr_arbiter: ID_WIDTH too narrow for NUM_REQ");
    end
    logic                  stage_ready, accept, any, last;
    logic [NUM_REQ-1:0]    req, grant;
    logic [ID_WIDTH-1:0]   grant_id, rr_ptr_q, rr_ptr_d, down_id_q, down_id_d;
    logic [WORD_WIDTH-1:0] win_data, down_data_q, down_data_d;
    logic                  down_valid_q, down_valid_d;
`ifdef HS_RR_ARB_LAST_LOCK_EN
    logic                  lock_q, lock_d, down_last_q, down_last_d;
    logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
    // a locked packet owner is the only eligible requester, even while idle
    assign req  = lock_q ? (up_valid & (NUM_REQ'(1) << lock_id_q)) : up_valid;
    assign last = |(up_last & grant);
    assign down_last = down_last_q;
`else
    assign req  = up_valid;
    assign last = 1'b1;
`endif
    rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .req      (req),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );
    assign stage_ready = down_ready | ~down_valid_q;
    assign accept      = stage_ready & any;
    assign up_ready    = grant & {NUM_REQ{stage_ready & rst_n}};
    assign down_valid  = down_valid_q;
    assign down_data   = down_data_q;
    assign down_id     = down_id_q;
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            win_data |= up_data[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{grant[i]}};
    end
    always_comb begin
        down_valid_d = accept | (down_valid_q & ~down_ready);
        down_data_d  = accept ? win_data : down_data_q;
        down_id_d    = accept ? grant_id : down_id_q;
        rr_ptr_d     = (accept & last) ? ID_WIDTH'(next_ptr(int'(grant_id), NUM_REQ)) : rr_ptr_q;
`ifdef HS_RR_ARB_LAST_LOCK_EN
        lock_d       = accept ? ~last : lock_q;
        lock_id_d    = accept ? grant_id : lock_id_q;
        down_last_d  = accept ? last : down_last_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_id_q    <= '0;
            rr_ptr_q     <= '0;
`ifdef HS_RR_ARB_LAST_LOCK_EN
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            down_last_q  <= 1'b0;
`endif
        end else begin
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_id_q    <= down_id_d;
            rr_ptr_q     <= rr_ptr_d;
`ifdef HS_RR_ARB_LAST_LOCK_EN
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            down_last_q  <= down_last_d;
`endif
        end
    end
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: scoreboard bench for hs_rr_arbiter with NUM_REQ=4, WORD_WIDTH=8
module tb_hs_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   up_valid = '0;
    logic [N*W-1:0] up_data = '0;
    logic [N-1:0]   up_ready;
    logic           down_valid;
    logic [W-1:0]   down_data;
    logic [1:0]     down_id;
    logic           down_ready = 1'b0;
`ifdef HS_RR_ARB_LAST_LOCK_EN
    logic [N-1:0]   up_last = '1;
    logic           down_last;
`endif
    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
        logic       l;
    } beat_t;
    beat_t sb[$];
    int total = 0;
    int bad = 0;
    logic       m_valid, m_lock, m_last;
    logic [1:0] m_ptr, m_id, m_lock_id;
    logic [7:0] m_data;

    hs_rr_arbiter #(.NUM_REQ(N), .WORD_WIDTH(W), .ID_WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_id    (down_id),
        .down_ready (down_ready)
`ifdef HS_RR_ARB_LAST_LOCK_EN
        ,
        .up_last    (up_last),
        .down_last  (down_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < N; i++) up_data[i*W +: W] = base + 8'(i);
    endtask

    task automatic model_reset();
        m_valid = 0; m_ptr = 0; m_id = 0; m_data = 0;
        m_lock = 0; m_lock_id = 0; m_last = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    // one clock: predict grant, check up_ready, then check the output stage after the edge
    task automatic cycle();
        logic sr, found, acc;
        logic [N-1:0] elig, exp_ready;
        int w;
        beat_t b;
        #1;
        sr = down_ready | ~m_valid;
        elig = up_valid;
        if (m_lock) elig = up_valid & (N'(1) << m_lock_id);
        found = 0;
        w = 0;
        for (int k = 0; k < N; k++) begin
            int idx = (int'(m_ptr) + k) % N;
            if (!found && elig[idx]) begin found = 1; w = idx; end
        end
        acc = sr & found;
        exp_ready = acc ? (N'(1) << w) : '0;
        total++;
        if (up_ready !== exp_ready) begin
            bad++;
            $display("FAIL up_ready got=%b want=%b t=%0t", up_ready, exp_ready, $time);
        end
        if (acc) begin
            b.id = 2'(w);
            b.d  = up_data[w*W +: W];
            b.l  = 1'b1;
`ifdef HS_RR_ARB_LAST_LOCK_EN
            b.l = up_last[w];
            m_lock = ~b.l;
            m_lock_id = 2'(w);
`endif
            sb.push_back(b);
            if (b.l) m_ptr = 2'((w + 1) % N);
            m_valid = 1;
        end else if (down_ready) m_valid = 0;
        @(posedge clk);
        #1;
        total++;
        if (down_valid !== m_valid) begin
            bad++;
            $display("FAIL down_valid got=%b want=%b t=%0t", down_valid, m_valid, $time);
        end
        if (acc) begin
            b = sb.pop_front();
            m_id = b.id; m_data = b.d; m_last = b.l;
        end
        if (m_valid) begin
            total++;
            if (down_id !== m_id || down_data !== m_data) begin
                bad++;
                $display("FAIL beat got id=%0d data=%h want id=%0d data=%h", down_id, down_data, m_id, m_data);
            end
`ifdef HS_RR_ARB_LAST_LOCK_EN
            total++;
            if (down_last !== m_last) begin
                bad++;
                $display("FAIL down_last got=%b want=%b", down_last, m_last);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst_n = 0; up_valid = '1; down_ready = 1; set_data(8'h10);
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (up_ready !== 4'b0000) begin bad++; $display("FAIL rst_up_ready got=%b want=0000", up_ready); end
        total++;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL rst_down_valid got=%b want=0", down_valid); end
        total++;
        if (down_data !== 8'h00) begin bad++; $display("FAIL rst_down_data got=%h want=00", down_data); end
        total++;
        if (down_id !== 2'd0) begin bad++; $display("FAIL rst_down_id got=%0d want=0", down_id); end
        rst_n = 1;
        model_reset();
        cycle();
        total++;
        if (down_id !== 2'd0) begin bad++; $display("FAIL first_grant got=%0d want=0", down_id); end
    endtask

    task automatic test_rotation();
        do_reset();
        up_valid = '1; set_data(8'h10); down_ready = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            total++;
            if (down_id !== 2'(i % 4) || down_data !== 8'(8'h10 + i % 4)) begin
                bad++;
                $display("FAIL rotation[%0d] got id=%0d data=%h want id=%0d", i, down_id, down_data, i % 4);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) cycle();
        total++;
        if (down_id !== 2'd2) begin bad++; $display("FAIL stall_setup got=%0d want=2", down_id); end
        down_ready = 0;
        for (int i = 0; i < 3; i++) cycle();
        down_ready = 1;
        cycle();
        total++;
        if (down_id !== 2'd3) begin bad++; $display("FAIL stall_resume got=%0d want=3", down_id); end
    endtask

    task automatic test_sparse();
        logic [1:0] exp_ids [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
        up_valid = 4'b0010;
        cycle();
        up_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (down_id !== exp_ids[i]) begin
                bad++;
                $display("FAIL sparse[%0d] got=%0d want=%0d", i, down_id, exp_ids[i]);
            end
        end
        up_valid = 4'b0010;
        for (int i = 0; i < 2; i++) cycle();
    endtask

    task automatic test_drain_accept();
        up_valid = 4'b0001;
        up_data[7:0] = 8'hAA;
        cycle();
        total++;
        if (down_data !== 8'hAA || down_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_accept got valid=%b data=%h want valid=1 data=aa", down_valid, down_data);
        end
        up_valid = '0;
        cycle();
        total++;
        if (down_valid !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b want=0", down_valid); end
        cycle();
        up_valid = '1; set_data(8'h30);
        for (int i = 0; i < 2; i++) cycle();
    endtask

    task automatic test_reset_mid();
        up_valid = '1; set_data(8'h40); down_ready = 1;
        cycle();
        down_ready = 0;
        rst_n = 0;
        #1;
        total++;
        if (up_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_up_ready got=%b want=0000", up_ready); end
        @(posedge clk);
        #1;
        total++;
        if (down_valid !== 1'b0 || down_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_rst_state got valid=%b id=%0d want valid=0 id=0", down_valid, down_id);
        end
        rst_n = 1;
        model_reset();
        down_ready = 1;
        cycle();
    endtask

`ifdef HS_RR_ARB_LAST_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_ids [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
        logic       exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        down_ready = 1; up_last = '1; up_valid = 4'b0010;
        cycle();
        up_valid = 4'b0111; set_data(8'h20); up_last = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) up_last = 4'b1111;
            cycle();
            total++;
            if (down_id !== exp_ids[i] || down_last !== exp_last[i]) begin
                bad++;
                $display("FAIL lock[%0d] got id=%0d last=%b want id=%0d last=%b", i, down_id, down_last, exp_ids[i], exp_last[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_stall();
        test_sparse();
        test_drain_accept();
        test_reset_mid();
`ifdef HS_RR_ARB_LAST_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
